// File: rtl/apx_err_monitor.sv
// rtl/apx_err_monitor.sv - error-metric accumulator for approximate multiplier outputs
module apx_err_monitor #(
  parameter int W     = 8,
  parameter int CNT_W = 16,
  parameter int SUM_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     op_a,
  input  logic [W-1:0]     op_b,
  input  logic [2*W-1:0]   prod_apx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] sum_ed,
  output logic             sum_sat,
  output logic [2*W-1:0]   max_ed,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] sample_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] acc_cnt;

  logic             s1_valid;
  logic [W-1:0]     s1_a;
  logic [W-1:0]     s1_b;
  logic [2*W-1:0]   s1_p;
  logic             s2_valid;
  logic [2*W-1:0]   s2_ed;

  logic             accept;
  logic             start_ok;
  logic [2*W-1:0]   exact;
  logic [2*W-1:0]   ed_c;
  logic [SUM_W:0]   sum_next;

  // Handshake and status decode; in_ready never looks at in_valid
  assign in_ready  = (state == RUN) && (acc_cnt < n_lat);
  assign accept    = in_valid && in_ready;
  assign busy      = (state == RUN) || (state == DRAIN);
  assign out_valid = (state == DONE);
  assign start_ok  = start && (state == IDLE);

  // Exact product and absolute error distance of the S1 sample
  assign exact    = {{W{1'b0}}, s1_a} * {{W{1'b0}}, s1_b};
  assign ed_c     = (exact >= s1_p) ? (exact - s1_p) : (s1_p - exact);
  // One guard bit above the accumulator catches overflow for saturation
  assign sum_next = {1'b0, sum_ed} + {{(SUM_W+1-2*W){1'b0}}, s2_ed};

  // Run control: count acceptances, then wait for the two pipe stages to empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      n_lat   <= '0;
      acc_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_lat   <= n_samples;
            acc_cnt <= '0;
            state   <= (n_samples == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (accept) acc_cnt <= acc_cnt + CNT_ONE;
          if (acc_cnt == n_lat) state <= DRAIN;
        end
        DRAIN: begin
          if (!s1_valid && !s2_valid) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-stage sample pipe: S1 captures the sample, S2 holds its error distance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_p     <= '0;
      s2_valid <= 1'b0;
      s2_ed    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a <= op_a;
        s1_b <= op_b;
        s1_p <= prod_apx;
      end
      s2_valid <= s1_valid;
      s2_ed    <= ed_c;
    end
  end

  // Metric accumulation; cleared by an honoured start, otherwise held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_ed     <= '0;
      sum_sat    <= 1'b0;
      max_ed     <= '0;
      err_cnt    <= '0;
      sample_cnt <= '0;
    end else if (start_ok) begin
      sum_ed     <= '0;
      sum_sat    <= 1'b0;
      max_ed     <= '0;
      err_cnt    <= '0;
      sample_cnt <= '0;
    end else if (s2_valid) begin
      if (sum_next[SUM_W]) begin
        sum_ed  <= '1;
        sum_sat <= 1'b1;
      end else begin
        sum_ed  <= sum_next[SUM_W-1:0];
      end
      if (s2_ed > max_ed) max_ed <= s2_ed;
      if (s2_ed != '0) err_cnt <= err_cnt + CNT_ONE;
      sample_cnt <= sample_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_apx_err_monitor.sv
// tb/tb_apx_err_monitor.sv - scoreboard bench for apx_err_monitor
module tb_apx_err_monitor;
  localparam int W = 8;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [CNT_W-1:0] n_samples = '0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [2*W-1:0] prod_apx = '0;

  logic busy, in_ready, out_valid, sum_sat;
  logic [31:0] sum_ed;
  logic [2*W-1:0] max_ed;
  logic [CNT_W-1:0] err_cnt, sample_cnt;

  logic busy16, in_ready16, out_valid16, sum_sat16;
  logic [15:0] sum_ed16;
  logic [2*W-1:0] max_ed16;
  logic [CNT_W-1:0] err_cnt16, sample_cnt16;

  apx_err_monitor #(.W(W), .CNT_W(CNT_W), .SUM_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b), .prod_apx(prod_apx),
    .out_valid(out_valid), .out_ready(out_ready), .sum_ed(sum_ed), .sum_sat(sum_sat),
    .max_ed(max_ed), .err_cnt(err_cnt), .sample_cnt(sample_cnt)
  );

  apx_err_monitor #(.W(W), .CNT_W(CNT_W), .SUM_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples), .busy(busy16),
    .in_valid(in_valid), .in_ready(in_ready16), .op_a(op_a), .op_b(op_b), .prod_apx(prod_apx),
    .out_valid(out_valid16), .out_ready(out_ready), .sum_ed(sum_ed16), .sum_sat(sum_sat16),
    .max_ed(max_ed16), .err_cnt(err_cnt16), .sample_cnt(sample_cnt16)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint s32;
    int     sat32;
    longint s16;
    int     sat16;
    int     mx;
    int     ec;
    int     sc;
  } exp_t;

  exp_t exp_q[$];
  int qa[$];
  int qb[$];
  int qp[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(string name, longint act, longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference: totals over the sample list, saturated at each accumulator width
  function automatic exp_t model();
    exp_t e;
    longint tot;
    int ed;
    e = '{default: 0};
    tot = 0;
    for (int i = 0; i < qa.size(); i++) begin
      ed = qa[i] * qb[i] - qp[i];
      if (ed < 0) ed = -ed;
      tot += ed;
      if (ed > e.mx) e.mx = ed;
      if (ed != 0) e.ec++;
    end
    e.sc = qa.size();
    e.sat32 = (tot > 64'hFFFF_FFFF) ? 1 : 0;
    e.s32 = (e.sat32 != 0) ? 64'hFFFF_FFFF : tot;
    e.sat16 = (tot > 65535) ? 1 : 0;
    e.s16 = (e.sat16 != 0) ? 65535 : tot;
    return e;
  endfunction

  // Monitor: every cycle a result is presented it must match the head of the queue
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = exp_q[0];
        chk("sum_ed", sum_ed, e.s32);
        chk("sum_sat", sum_sat, e.sat32);
        chk("max_ed", max_ed, e.mx);
        chk("err_cnt", err_cnt, e.ec);
        chk("sample_cnt", sample_cnt, e.sc);
        chk("out_valid16", out_valid16, 1);
        chk("sum_ed16", sum_ed16, e.s16);
        chk("sum_sat16", sum_sat16, e.sat16);
        chk("in_ready_done", in_ready, 0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send_one(int a, int b, int p, int gap);
    bit ok;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    op_a = a[W-1:0];
    op_b = b[W-1:0];
    prod_apx = p[2*W-1:0];
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_timeout", ok, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_run(int hold, int maxgap, int lat_exp, bit dbl_start);
    int n;
    int k;
    bit seen;
    n = qa.size();
    exp_q.push_back(model());
    n_samples = n[CNT_W-1:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, (n != 0) ? 1 : 0);
    if (n == 0) chk("in_ready_n0", in_ready, 0);
    if (dbl_start && n > 0) begin
      n_samples = 7;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < n; i++) send_one(qa[i], qb[i], qp[i], $urandom_range(0, maxgap));
    seen = 1'b0;
    for (k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (n == 0 && in_ready) chk("in_ready_n0_wait", in_ready, 0);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_timeout", seen, 1);
    if (lat_exp != 0) chk("done_latency", k, lat_exp);
    @(posedge clk); #1;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      op_a = W'($urandom);
      op_b = W'($urandom);
      prod_apx = 16'($urandom);
      start = (i == 0);
      n_samples = 3;
      @(posedge clk); #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic clear_samples();
    qa.delete();
    qb.delete();
    qp.delete();
  endtask

  task automatic add(int a, int b, int p);
    qa.push_back(a);
    qb.push_back(b);
    qp.push_back(p);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_sum_ed"}, sum_ed, 0);
    chk({tag, "_sum_sat"}, sum_sat, 0);
    chk({tag, "_max_ed"}, max_ed, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_sample_cnt"}, sample_cnt, 0);
    chk({tag, "_sum_ed16"}, sum_ed16, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, p, n, mode;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: exact products, no error
    clear_samples();
    add(3, 5, 15); add(255, 255, 65025); add(0, 9, 0); add(17, 16, 272);
    do_run(0, 0, 0, 1'b0);

    // T2: single worst-case sample, latency to DONE
    clear_samples();
    add(255, 255, 0);
    do_run(1, 0, 4, 1'b0);

    // T3: EDs 10, 0, 7 with input gaps and a held result
    clear_samples();
    add(10, 10, 110); add(4, 4, 16); add(3, 3, 2);
    do_run(5, 3, 0, 1'b0);

    // T4: empty run
    clear_samples();
    do_run(2, 0, 1, 1'b0);

    // T5: saturation of the narrow accumulator
    clear_samples();
    add(255, 255, 25025); add(255, 255, 25025); add(255, 255, 25025);
    do_run(1, 1, 0, 1'b0);

    // T6: asynchronous abort mid-run, then a clean run ignoring a second start
    clear_samples();
    n_samples = 5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_one(200, 100, 1, 0);
    send_one(7, 9, 60, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    add(12, 12, 100);
    do_run(1, 0, 4, 1'b1);

    // Randomized runs
    for (int r = 0; r < 25; r++) begin
      clear_samples();
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) begin
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
        mode = $urandom_range(0, 2);
        if (mode == 0) p = a * b;
        else if (mode == 1) begin
          p = a * b + $urandom_range(0, 64) - 32;
          if (p < 0) p = 0;
          if (p > 65535) p = 65535;
        end else p = $urandom_range(0, 65535);
        add(a, b, p);
      end
      do_run($urandom_range(0, 3), $urandom_range(0, 2), 0, 1'b0);
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
